// File: rtl/cont_mod_n.sv
// Synchronous modulo-N up/down counter with parallel load and a cascadable terminal count.
// Define CONT_MOD_N_WRAP_FLAG_EN to add the sticky `wrapped` flag and its `wrap_clr` input.
module cont_mod_n #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
`ifdef CONT_MOD_N_WRAP_FLAG_EN
    input  logic             wrap_clr,
    output logic             wrapped,
`endif
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    // MODULUS may equal 2^WIDTH, so the range compare needs one extra bit.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ZERO    = '0;
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] loadVal;
    logic             atMax;
    logic             atZero;

    always_comb begin
        atMax   = (count_q == MAX_VAL);
        atZero  = (count_q == ZERO);
        loadVal = ({1'b0, din} < MOD_EXT) ? din : ZERO;
        count_d = count_q;
        if (load) begin
            count_d = loadVal;
        end else if (en) begin
            if (up) begin
                count_d = atMax ? ZERO : count_q + ONE;
            end else begin
                count_d = atZero ? MAX_VAL : count_q - ONE;
            end
        end
    end

    // Gated by clear_n so a held-down counter at 0 never advertises a down-wrap.
    assign tc = clear_n & en & ~load & ((up & atMax) | (~up & atZero));

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            count_q <= ZERO;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

`ifdef CONT_MOD_N_WRAP_FLAG_EN
    logic wrapped_q;

    // A wrap on the same edge as wrap_clr keeps the flag set.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            wrapped_q <= 1'b0;
        end else if (tc) begin
            wrapped_q <= 1'b1;
        end else if (wrap_clr) begin
            wrapped_q <= 1'b0;
        end
    end

    assign wrapped = wrapped_q;
`endif

endmodule

// File: tb/tb_cont_mod_n.sv
// Directed self-checking bench for cont_mod_n: decimal digit, cascaded pair and a modulo-8 instance.
// The sticky wrap flag scenario is exercised when CONT_MOD_N_WRAP_FLAG_EN is defined.
module tb_cont_mod_n;

    logic       clk;
    logic       clear_n;
    logic       en;
    logic       up;
    logic       load;
    logic [3:0] din;
    logic [3:0] count;
    logic       tc;

    logic       casEn;
    logic [3:0] unitsCount;
    logic [3:0] tensCount;
    logic       unitsTc;
    logic       tensTc;

    logic       en8;
    logic       up8;
    logic [2:0] count8;
    logic       tc8;

`ifdef CONT_MOD_N_WRAP_FLAG_EN
    logic       wrap_clr;
    logic       wrapped;
    logic       unitsWrapped;
    logic       tensWrapped;
    logic       wrapped8;
`endif

    int checks;
    int failures;

    cont_mod_n #(.WIDTH(4), .MODULUS(10)) dut (
        .clk     (clk),
        .clear_n (clear_n),
        .en      (en),
        .up      (up),
        .load    (load),
        .din     (din),
`ifdef CONT_MOD_N_WRAP_FLAG_EN
        .wrap_clr(wrap_clr),
        .wrapped (wrapped),
`endif
        .count   (count),
        .tc      (tc)
    );

    cont_mod_n #(.WIDTH(4), .MODULUS(10)) units (
        .clk     (clk),
        .clear_n (clear_n),
        .en      (casEn),
        .up      (1'b1),
        .load    (1'b0),
        .din     (4'd0),
`ifdef CONT_MOD_N_WRAP_FLAG_EN
        .wrap_clr(1'b0),
        .wrapped (unitsWrapped),
`endif
        .count   (unitsCount),
        .tc      (unitsTc)
    );

    cont_mod_n #(.WIDTH(4), .MODULUS(10)) tens (
        .clk     (clk),
        .clear_n (clear_n),
        .en      (unitsTc),
        .up      (1'b1),
        .load    (1'b0),
        .din     (4'd0),
`ifdef CONT_MOD_N_WRAP_FLAG_EN
        .wrap_clr(1'b0),
        .wrapped (tensWrapped),
`endif
        .count   (tensCount),
        .tc      (tensTc)
    );

    cont_mod_n #(.WIDTH(3), .MODULUS(8)) dut8 (
        .clk     (clk),
        .clear_n (clear_n),
        .en      (en8),
        .up      (up8),
        .load    (1'b0),
        .din     (3'd0),
`ifdef CONT_MOD_N_WRAP_FLAG_EN
        .wrap_clr(1'b0),
        .wrapped (wrapped8),
`endif
        .count   (count8),
        .tc      (tc8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear_n = 1'b0; en = 1'b1; up = 1'b0; load = 1'b0; din = 4'd0;
        #2;
        checks++;
        if (count !== 4'd0) begin failures++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
        checks++;
        if (tc !== 1'b0) begin failures++; $display("[TB] FAIL reset_tc_down: got %b expected 0", tc); end
        load = 1'b1; din = 4'd5;
        tick();
        checks++;
        if (count !== 4'd0) begin failures++; $display("[TB] FAIL reset_hold_load: got %0d expected 0", count); end
        load = 1'b0;
        #1;
        checks++;
        if (tc !== 1'b0) begin failures++; $display("[TB] FAIL reset_tc_held: got %b expected 0", tc); end
        checks++;
        if (count8 !== 3'd0) begin failures++; $display("[TB] FAIL reset_count8: got %0d expected 0", count8); end
        en = 1'b0;
        clear_n = 1'b1;
        #1;
    endtask

    task automatic test_count_up();
        int exp;
        exp = 0;
        en = 1'b1; up = 1'b1; load = 1'b0;
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (tc !== (exp == 9)) begin failures++; $display("[TB] FAIL up_tc step %0d: got %b expected %b", i, tc, (exp == 9)); end
            tick();
            exp = (exp + 1) % 10;
            checks++;
            if (count !== 4'(exp)) begin failures++; $display("[TB] FAIL up_count step %0d: got %0d expected %0d", i, count, exp); end
        end
        en = 1'b0;
        tick();
        checks++;
        if (count !== 4'd2) begin failures++; $display("[TB] FAIL hold_count: got %0d expected 2", count); end
        checks++;
        if (tc !== 1'b0) begin failures++; $display("[TB] FAIL hold_tc: got %b expected 0", tc); end
    endtask

    task automatic test_count_down();
        load = 1'b1; din = 4'd0; en = 1'b0;
        tick();
        load = 1'b0; en = 1'b1; up = 1'b0;
        #1;
        checks++;
        if (tc !== 1'b1) begin failures++; $display("[TB] FAIL down_tc_at0: got %b expected 1", tc); end
        tick();
        checks++;
        if (count !== 4'd9) begin failures++; $display("[TB] FAIL down_wrap: got %0d expected 9", count); end
        checks++;
        if (tc !== 1'b0) begin failures++; $display("[TB] FAIL down_tc_at9: got %b expected 0", tc); end
        tick();
        checks++;
        if (count !== 4'd8) begin failures++; $display("[TB] FAIL down_8: got %0d expected 8", count); end
        tick();
        checks++;
        if (count !== 4'd7) begin failures++; $display("[TB] FAIL down_7: got %0d expected 7", count); end
        en = 1'b0;
    endtask

    task automatic test_load();
        load = 1'b1; din = 4'd9; en = 1'b0;
        tick();
        checks++;
        if (count !== 4'd9) begin failures++; $display("[TB] FAIL load_9: got %0d expected 9", count); end
        en = 1'b1; up = 1'b1; din = 4'd7;
        #1;
        checks++;
        if (tc !== 1'b0) begin failures++; $display("[TB] FAIL load_masks_tc: got %b expected 0", tc); end
        tick();
        checks++;
        if (count !== 4'd7) begin failures++; $display("[TB] FAIL load_7: got %0d expected 7", count); end
        din = 4'd12;
        tick();
        checks++;
        if (count !== 4'd0) begin failures++; $display("[TB] FAIL load_12: got %0d expected 0", count); end
        din = 4'd9;
        tick();
        din = 4'd10;
        tick();
        checks++;
        if (count !== 4'd0) begin failures++; $display("[TB] FAIL load_10: got %0d expected 0", count); end
        din = 4'd15; up = 1'b0;
        tick();
        checks++;
        if (count !== 4'd0) begin failures++; $display("[TB] FAIL load_15: got %0d expected 0", count); end
        load = 1'b0; en = 1'b0;
    endtask

    task automatic test_direction();
        load = 1'b1; din = 4'd5;
        tick();
        load = 1'b0; en = 1'b1; up = 1'b1;
        tick();
        checks++;
        if (count !== 4'd6) begin failures++; $display("[TB] FAIL dir_up6: got %0d expected 6", count); end
        up = 1'b0;
        tick();
        checks++;
        if (count !== 4'd5) begin failures++; $display("[TB] FAIL dir_down5: got %0d expected 5", count); end
        up = 1'b1;
        tick();
        checks++;
        if (count !== 4'd6) begin failures++; $display("[TB] FAIL dir_up6b: got %0d expected 6", count); end
        load = 1'b1; din = 4'd9;
        tick();
        load = 1'b0; up = 1'b0;
        #1;
        checks++;
        if (tc !== 1'b0) begin failures++; $display("[TB] FAIL dir_tc9_down: got %b expected 0", tc); end
        tick();
        checks++;
        if (count !== 4'd8) begin failures++; $display("[TB] FAIL dir_down8: got %0d expected 8", count); end
        en = 1'b0;
    endtask

    task automatic test_async_clear();
        load = 1'b1; din = 4'd6;
        tick();
        load = 1'b0; en = 1'b0;
        checks++;
        if (count !== 4'd6) begin failures++; $display("[TB] FAIL aclr_pre: got %0d expected 6", count); end
        #2;
        clear_n = 1'b0;
        #1;
        checks++;
        if (count !== 4'd0) begin failures++; $display("[TB] FAIL aclr_immediate: got %0d expected 0", count); end
        en = 1'b1; up = 1'b1; load = 1'b1; din = 4'd4;
        tick();
        checks++;
        if (count !== 4'd0) begin failures++; $display("[TB] FAIL aclr_held: got %0d expected 0", count); end
        clear_n = 1'b1; load = 1'b0;
        tick();
        checks++;
        if (count !== 4'd1) begin failures++; $display("[TB] FAIL aclr_first_edge: got %0d expected 1", count); end
        en = 1'b0;
    endtask

    task automatic test_cascade();
        clear_n = 1'b0;
        #1;
        clear_n = 1'b1;
        casEn = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        checks++;
        if (unitsTc !== 1'b1) begin failures++; $display("[TB] FAIL cascade_carry: got %b expected 1", unitsTc); end
        checks++;
        if (tensCount !== 4'd0) begin failures++; $display("[TB] FAIL cascade_tens9: got %0d expected 0", tensCount); end
        for (int i = 0; i < 16; i++) tick();
        casEn = 1'b0;
        checks++;
        if (unitsCount !== 4'd5) begin failures++; $display("[TB] FAIL cascade_units: got %0d expected 5", unitsCount); end
        checks++;
        if (tensCount !== 4'd2) begin failures++; $display("[TB] FAIL cascade_tens: got %0d expected 2", tensCount); end
    endtask

    task automatic test_mod8();
        int exp;
        clear_n = 1'b0;
        #1;
        clear_n = 1'b1;
        exp = 0;
        en8 = 1'b1; up8 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (tc8 !== (exp == 7)) begin failures++; $display("[TB] FAIL mod8_tc step %0d: got %b expected %b", i, tc8, (exp == 7)); end
            tick();
            exp = (exp + 1) % 8;
            checks++;
            if (count8 !== 3'(exp)) begin failures++; $display("[TB] FAIL mod8_count step %0d: got %0d expected %0d", i, count8, exp); end
        end
        up8 = 1'b0;
        #1;
        checks++;
        if (tc8 !== 1'b1) begin failures++; $display("[TB] FAIL mod8_down_tc: got %b expected 1", tc8); end
        tick();
        checks++;
        if (count8 !== 3'd7) begin failures++; $display("[TB] FAIL mod8_down_wrap: got %0d expected 7", count8); end
        en8 = 1'b0;
    endtask

`ifdef CONT_MOD_N_WRAP_FLAG_EN
    task automatic test_wrap_flag();
        clear_n = 1'b0;
        #1;
        clear_n = 1'b1; wrap_clr = 1'b0;
        checks++;
        if (wrapped !== 1'b0) begin failures++; $display("[TB] FAIL wrap_reset: got %b expected 0", wrapped); end
        load = 1'b1; din = 4'd9; en = 1'b0;
        tick();
        load = 1'b0; en = 1'b1; up = 1'b1;
        tick();
        checks++;
        if (wrapped !== 1'b1) begin failures++; $display("[TB] FAIL wrap_set: got %b expected 1", wrapped); end
        en = 1'b0;
        tick();
        checks++;
        if (wrapped !== 1'b1) begin failures++; $display("[TB] FAIL wrap_sticky: got %b expected 1", wrapped); end
        wrap_clr = 1'b1;
        tick();
        checks++;
        if (wrapped !== 1'b0) begin failures++; $display("[TB] FAIL wrap_clear: got %b expected 0", wrapped); end
        wrap_clr = 1'b0; load = 1'b1; din = 4'd9;
        tick();
        load = 1'b0; en = 1'b1; wrap_clr = 1'b1;
        tick();
        checks++;
        if (wrapped !== 1'b1) begin failures++; $display("[TB] FAIL wrap_set_wins: got %b expected 1", wrapped); end
        en = 1'b0; wrap_clr = 1'b0;
        #2;
        clear_n = 1'b0;
        #1;
        checks++;
        if (wrapped !== 1'b0) begin failures++; $display("[TB] FAIL wrap_async_clear: got %b expected 0", wrapped); end
        clear_n = 1'b1;
    endtask
`endif

    initial begin
        checks = 0;
        failures = 0;
        clear_n = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; din = 4'd0;
        casEn = 1'b0; en8 = 1'b0; up8 = 1'b1;
`ifdef CONT_MOD_N_WRAP_FLAG_EN
        wrap_clr = 1'b0;
`endif
        test_reset();
        test_count_up();
        test_count_down();
        test_load();
        test_direction();
        test_async_clear();
        test_cascade();
        test_mod8();
`ifdef CONT_MOD_N_WRAP_FLAG_EN
        test_wrap_flag();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cont_mod_n.md
CONT_MOD_N -- requirements
Module: cont_mod_n

Interface
REQ-001 Parameter WIDTH, default 4, counter register width in bits.
REQ-002 Parameter MODULUS, default 10, count sequence length; legal range 2 <= MODULUS <= 2^WIDTH.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 clear_n  input  1  reset is asynchronous and active-low.
REQ-005 en  input  1  count enable; high = advance one step this edge.
REQ-006 up  input  1  direction; 1 = count up, 0 = count down.
REQ-007 load  input  1  synchronous parallel load strobe.
REQ-008 din  input  WIDTH  parallel load value.
REQ-009 count  output  WIDTH  registered counter value, always in 0..MODULUS-1.
REQ-010 tc  output  1  combinational terminal-count/carry for cascading the next digit's en.
REQ-011 wrapped  output  1  sticky wrap flag; present only when the configuration macro is defined.
REQ-012 wrap_clr  input  1  synchronous clear of wrapped; present only when the configuration macro is defined.

Function
REQ-013 All count bits SHALL update on the same clk rising edge (fully synchronous; no ripple clocking between bits).
REQ-014 Per-edge priority SHALL be: clear_n low > load > en > hold.
REQ-015 load=1: count SHALL become din if din < MODULUS, else 0, regardless of en and up.
REQ-016 load=0, en=1, up=1: count SHALL go count+1, wrapping MODULUS-1 -> 0.
REQ-017 load=0, en=1, up=0: count SHALL go count-1, wrapping 0 -> MODULUS-1.
REQ-018 load=0, en=0: count SHALL hold.
REQ-019 tc SHALL equal en & ~load & ((up & count==MODULUS-1) | (~up & count==0)), zero latency from inputs.
REQ-020 tc high SHALL coincide exactly with the cycle whose edge performs a wrap.
REQ-021 Direction change takes effect on the same edge; no extra cycle, no skipped value.
REQ-022 For MODULUS = 2^WIDTH the sequence SHALL be natural binary wrap with no lost state.
REQ-023 Out-of-range count values SHALL be unreachable from any input sequence.

Reset
REQ-024 clear_n low SHALL immediately, without clk, force count=0 (and wrapped=0 when compiled in).
REQ-025 While clear_n is low, count SHALL stay 0 and tc SHALL be 0 irrespective of en, load, up.
REQ-026 On clear_n deassertion, the first rising clk edge SHALL behave per REQ-014 from count=0.
REQ-027 Reset asserted mid-sequence SHALL abort that sequence; no partial update survives.

Configuration
REQ-028 Macro CONT_MOD_N_WRAP_FLAG_EN SHALL control the sticky wrap flag.
REQ-029 Defined: wrapped SHALL set on any edge where tc=1, stay set until wrap_clr=1 or reset; wrap_clr and a wrap on the same edge leave wrapped=1 (set wins).
REQ-030 Undefined: wrapped and wrap_clr ports and their register SHALL not exist; all other behaviour identical.

Verification (WIDTH=4, MODULUS=10 unless stated)
REQ-031 Reset, en=1, up=1 for 12 edges -> count 1..9,0,1,2; tc=1 only while count=9.
REQ-032 up=0 from count=0, en=1, 3 edges -> count 9,8,7; tc=1 only in the cycle count=0.
REQ-033 load=1, din=7, en=1 -> count=7, tc=0; then load=1, din=12 -> count=0.
REQ-034 clear_n pulsed low between edges at count=6 -> count=0 immediately, before next clk edge.
REQ-035 Two instances cascaded (units tc -> tens en), 25 edges from reset -> tens=2, units=5.
REQ-036 With CONT_MOD_N_WRAP_FLAG_EN: wrap at 9->0 sets wrapped=1; wrap_clr=1 next edge -> 0; WIDTH=3, MODULUS=8 wraps 7->0.
